read_wait_gen: RTL and testbench

- Downstream read responder for the rd/ds read-handshake FSM.
- Consumes the FSM's `rd` strobe and produces its `ws` (wait-state) input.
- Holds a small register-file memory. On each read request it inserts a programmable number of wait cycles before releasing `ws` and presenting `rdata`.
- Gives the requesting FSM a real, cycle-accurate slave to loop READ/DLY against.

---
 rtl/read_wait_pkg.sv | 18 +
 rtl/read_wait_gen_ws_lfsr.sv | 24 ++
 rtl/read_wait_gen.sv | 114 +++++++++++
 tb/tb_read_wait_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/read_wait_pkg.sv
// rtl/read_wait_pkg.sv - shared types and LFSR constants for read_wait_gen
package read_wait_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } rw_state_t;

    localparam logic [3:0] LFSR_SEED  = 4'b0001;
    localparam int         LFSR_TAP_A = 3;
    localparam int         LFSR_TAP_B = 2;

    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        return {v[2:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/read_wait_gen_ws_lfsr.sv
// rtl/read_wait_gen_ws_lfsr.sv - 4-bit wait-count LFSR, advanced once per accepted read
module ws_lfsr
    import read_wait_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adv,
    output logic [3:0] q
);

    logic [3:0] lfsr_q;

    // Shift only when a request is accepted so each read consumes one value
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (adv) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/read_wait_gen.sv
// rtl/read_wait_gen.sv - read responder inserting programmable wait states; WS_LFSR_EN selects LFSR wait counts
module read_wait_gen
    import read_wait_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ws,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    localparam int DEPTH = 1 << ADDR_W;

    rw_state_t         state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic [WAIT_W-1:0] wait_n;
    logic [DATA_W-1:0] rdata_d;

    assign accept = (state_q == IDLE) && rd;

`ifdef WS_LFSR_EN
    logic [3:0] lfsr_q;

    if (WAIT_W != 4) begin : g_bad_wait_w
        $error("read_wait_gen: WS_LFSR_EN requires WAIT_W == 4");
    end

    ws_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (accept),
        .q       (lfsr_q)
    );

    assign wait_n = WAIT_W'(lfsr_q);
`else
    assign wait_n = wait_cfg;
`endif

    // In IDLE the live address is used (zero-wait capture), otherwise the latched one
    assign rdata_d = mem_q[(state_q == IDLE) ? addr : addr_q];

    // Request FSM: accept, count down wait cycles, present data, release on rd low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd) begin
                        addr_q <= addr;
                        if (wait_n == '0) begin
                            state_q <= READY;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= wait_n;
                        end
                    end
                end
                WAIT: begin
                    if (!rd) begin
                        state_q <= IDLE;
                    end else if (cnt_q == WAIT_W'(1)) begin
                        state_q <= READY;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                READY: begin
                    if (!rd) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register-file memory; capture above reads the pre-write contents on a shared edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ws     = (state_q != READY);
    assign rvalid = (state_q == READY);
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_read_wait_gen.sv
// tb/tb_read_wait_gen.sv - randomized directed bench for read_wait_gen against a latency/memory model
module tb_read_wait_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rd;
    logic [3:0] addr;
    logic [3:0] wait_cfg;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       ws;
    logic [7:0] rdata;
    logic       rvalid;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_m [16];
    logic [7:0] rdata_m;
    logic [3:0] lfsr_m;

    read_wait_gen #(.DATA_W(8), .ADDR_W(4), .WAIT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd       (rd),
        .addr     (addr),
        .wait_cfg (wait_cfg),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .ws       (ws),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Effective wait count for the next accepted request
    function automatic int eff_n(input int cfg);
`ifdef WS_LFSR_EN
        int n;
        n = int'(lfsr_m);
        lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
        return n;
`else
        return cfg;
`endif
    endfunction

    task automatic mem_write(input int a, input int d);
        we    = 1'b1;
        waddr = 4'(a);
        wdata = 8'(d);
        @(posedge clk);
        mem_m[a] = 8'(d);
        #1;
        we = 1'b0;
    endtask

    task automatic read_txn(input int a, input int cfg, input int hold, input bit cw, input int cw_d);
        int n;
        logic [7:0] exp_cap;
        n = eff_n(cfg);
        exp_cap = 8'h00;
        rd = 1'b1;
        addr = 4'(a);
        wait_cfg = 4'(cfg);
        chk("idle_ws", 32'(ws), 32'd1);
        chk("idle_rvalid", 32'(rvalid), 32'd0);
        for (int k = 1; k <= n + 1; k++) begin
            if (k == n + 1 && cw) begin
                we = 1'b1; waddr = 4'(a); wdata = 8'(cw_d);
            end else if ($urandom_range(3) == 0) begin
                we = 1'b1; waddr = 4'($urandom_range(15)); wdata = 8'($urandom);
            end else begin
                we = 1'b0;
            end
            if (k == n + 1) exp_cap = mem_m[a];
            @(posedge clk);
            if (we) mem_m[waddr] = wdata;
            #1;
            we = 1'b0;
            if (k == 1) begin
                wait_cfg = 4'($urandom);
                addr     = 4'($urandom);
            end
            if (k == n + 1) rdata_m = exp_cap;
            chk("wait_ws", 32'(ws), (k == n + 1) ? 32'd0 : 32'd1);
            chk("wait_rvalid", 32'(rvalid), (k == n + 1) ? 32'd1 : 32'd0);
            chk("wait_rdata", 32'(rdata), 32'(rdata_m));
        end
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_rvalid", 32'(rvalid), 32'd1);
            chk("hold_rdata", 32'(rdata), 32'(rdata_m));
        end
        rd = 1'b0;
        step();
        chk("drop_ws", 32'(ws), 32'd1);
        chk("drop_rvalid", 32'(rvalid), 32'd0);
        chk("drop_rdata", 32'(rdata), 32'(rdata_m));
    endtask

    task automatic abort_txn(input int a, input int cfg, input int d);
        int n;
        int dd;
        n = eff_n(cfg);
        dd = (d < n) ? d : n;
        rd = 1'b1;
        addr = 4'(a);
        wait_cfg = 4'(cfg);
        for (int k = 1; k <= dd; k++) begin
            step();
            chk("abort_ws", 32'(ws), 32'd1);
            chk("abort_rvalid", 32'(rvalid), 32'd0);
        end
        rd = 1'b0;
        step();
        chk("abort_idle_ws", 32'(ws), 32'd1);
        chk("abort_idle_rvalid", 32'(rvalid), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'(rdata_m));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        rdata_m = 8'h00;
        lfsr_m  = 4'b0001;
    endfunction

    initial begin
        reset_n = 1'b0; rd = 1'b0; addr = '0; wait_cfg = '0;
        we = 1'b0; waddr = '0; wdata = '0;
        model_reset();
        step();
        step();
        chk("reset_ws", 32'(ws), 32'd1);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        reset_n = 1'b1;
        step();

        mem_write(3, 8'hA5);
        read_txn(3, 0, 1, 1'b0, 0);
        chk("zero_wait_a5", 32'(rdata), 32'h0A5);

        mem_write(7, 8'h3C);
        read_txn(7, 3, 2, 1'b0, 0);
        chk("three_wait_3c", 32'(rdata), 32'h03C);

        abort_txn(9, 5, 2);

        mem_write(2, 8'h11);
        read_txn(2, 1, 0, 1'b1, 8'h22);
        chk("same_edge_old", 32'(rdata), 32'h011);
        read_txn(2, 0, 0, 1'b0, 0);
        chk("same_edge_new", 32'(rdata), 32'h022);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(3))
                0: mem_write(int'($urandom_range(15)), int'($urandom_range(255)));
                1: abort_txn(int'($urandom_range(15)), int'($urandom_range(15, 1)), int'($urandom_range(4, 1)));
                default: read_txn(int'($urandom_range(15)), int'($urandom_range(15)),
                                  int'($urandom_range(2)), 1'($urandom_range(1)), int'($urandom_range(255)));
            endcase
        end

        mem_write(5, 8'h5A);
        rd = 1'b1; addr = 4'd5; wait_cfg = 4'd5;
        void'(eff_n(5));
        step();
        step();
        chk("midwait_ws", 32'(ws), 32'd1);
        reset_n = 1'b0;
        step();
        chk("midrst_ws", 32'(ws), 32'd1);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        reset_n = 1'b1;
        rd = 1'b0;
        model_reset();
        step();
        read_txn(5, 0, 0, 1'b0, 0);
        chk("cleared_mem5", 32'(rdata), 32'd0);
        read_txn(3, 0, 0, 1'b0, 0);
        read_txn(7, 2, 0, 1'b0, 0);
        read_txn(2, 1, 1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
